// File: rtl/cv32e40s_pc_check_sched.sv
// Schedules PC-hardening compares: arms one expected PC, holds it across IF stalls, and checks it once.
// Optional statistics counters are enabled with `define CV32E40S_PC_CHECK_STATS_EN.

module cv32e40s_pc_check_sched #(
  parameter int unsigned IGN_LSB = 1
`ifdef CV32E40S_PC_CHECK_STATS_EN
  ,
  parameter int unsigned STAT_W  = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        pc_set_i,
  input  logic        pc_set_chk_i,
  input  logic [31:0] pc_set_target_i,
  input  logic        seq_push_i,
  input  logic [31:0] seq_addr_i,
  input  logic        kill_if_i,
  input  logic        if_valid_i,
  input  logic [31:0] pc_if_i,
  output logic        pending_o,
  output logic        alert_o,
  output logic        err_sticky_o
`ifdef CV32E40S_PC_CHECK_STATS_EN
  ,
  output logic [STAT_W-1:0] cmp_cnt_o,
  output logic [STAT_W-1:0] drop_cnt_o
`endif
);

  // state   | meaning
  // IDLE    | nothing armed
  // ARM_SEQ | expectation armed from a sequential IF->ID transfer
  // ARM_CF  | expectation armed from a checkable pc_set
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_SEQ = 2'd1,
    ARM_CF  = 2'd2
  } state_e;

  // Alignment bits below IGN_LSB never participate in the compare.
  localparam logic [31:0] CMP_MASK = 32'hFFFF_FFFF << IGN_LSB;

  state_e      state_q, state_d;
  logic [31:0] exp_q, exp_d;
  logic        alert_q, alert_d;
  logic        err_sticky_q, err_sticky_d;
  logic        armed;
  logic        cmp_fire;
  logic        mismatch;
  logic        drop_evt;

  assign armed    = (state_q != IDLE);
  assign cmp_fire = enable_i && armed && if_valid_i && !kill_if_i && !pc_set_i;
  assign mismatch = |((exp_q ^ pc_if_i) & CMP_MASK);

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    drop_evt     = 1'b0;
    alert_d      = cmp_fire && mismatch;
    err_sticky_d = err_sticky_q | (cmp_fire && mismatch);

    if (!enable_i) begin
      state_d  = IDLE;
      drop_evt = armed;
    end else if (pc_set_i && pc_set_chk_i) begin
      state_d = ARM_CF;
      exp_d   = pc_set_target_i;
    end else if (pc_set_i) begin
      state_d  = IDLE;
      drop_evt = armed;
    end else if (kill_if_i) begin
      state_d  = IDLE;
      drop_evt = armed;
    end else if (seq_push_i) begin
      // Any same-cycle compare already used the old exp_q.
      state_d = ARM_SEQ;
      exp_d   = seq_addr_i;
    end else if (cmp_fire) begin
      state_d = IDLE;
    end
  end

`ifdef CV32E40S_PC_CHECK_STATS_EN
  logic [STAT_W-1:0] cmp_cnt_q, cmp_cnt_d;
  logic [STAT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    cmp_cnt_d  = cmp_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (cmp_fire && (cmp_cnt_q != {STAT_W{1'b1}})) begin
      cmp_cnt_d = cmp_cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end
    if (drop_evt && (drop_cnt_q != {STAT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      cmp_cnt_q  <= cmp_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign cmp_cnt_o  = cmp_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      exp_q        <= '0;
      alert_q      <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      alert_q      <= alert_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign pending_o    = armed;
  assign alert_o      = alert_q;
  assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_cv32e40s_pc_check_sched.sv
// Directed, table-driven bench for the PC-check scheduler (IGN_LSB = 1).
// Each vector is driven for one cycle; outputs are checked just after the following edge.

module tb_cv32e40s_pc_check_sched;

  logic        clk;
  logic        rst_n;
  logic        enable_i;
  logic        pc_set_i;
  logic        pc_set_chk_i;
  logic [31:0] pc_set_target_i;
  logic        seq_push_i;
  logic [31:0] seq_addr_i;
  logic        kill_if_i;
  logic        if_valid_i;
  logic [31:0] pc_if_i;
  logic        pending_o;
  logic        alert_o;
  logic        err_sticky_o;
`ifdef CV32E40S_PC_CHECK_STATS_EN
  logic [15:0] cmp_cnt_o;
  logic [15:0] drop_cnt_o;
`endif

  cv32e40s_pc_check_sched #(
    .IGN_LSB(1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable_i        (enable_i),
    .pc_set_i        (pc_set_i),
    .pc_set_chk_i    (pc_set_chk_i),
    .pc_set_target_i (pc_set_target_i),
    .seq_push_i      (seq_push_i),
    .seq_addr_i      (seq_addr_i),
    .kill_if_i       (kill_if_i),
    .if_valid_i      (if_valid_i),
    .pc_if_i         (pc_if_i),
    .pending_o       (pending_o),
    .alert_o         (alert_o),
    .err_sticky_o    (err_sticky_o)
`ifdef CV32E40S_PC_CHECK_STATS_EN
    ,
    .cmp_cnt_o       (cmp_cnt_o),
    .drop_cnt_o      (drop_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        ps;
    logic        chk;
    logic [31:0] tgt;
    logic        sp;
    logic [31:0] sa;
    logic        kill;
    logic        iv;
    logic [31:0] pc;
    logic        e_pend;
    logic        e_alert;
    logic        e_sticky;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs[NVEC];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic en, logic ps, logic chk, logic [31:0] tgt,
                              logic sp, logic [31:0] sa, logic kill, logic iv,
                              logic [31:0] pc, logic ep, logic ea, logic es);
    vec_t v;
    v.en = en; v.ps = ps; v.chk = chk; v.tgt = tgt;
    v.sp = sp; v.sa = sa; v.kill = kill; v.iv = iv; v.pc = pc;
    v.e_pend = ep; v.e_alert = ea; v.e_sticky = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    enable_i        = 1'b1;
    pc_set_i        = 1'b0;
    pc_set_chk_i    = 1'b0;
    pc_set_target_i = '0;
    seq_push_i      = 1'b0;
    seq_addr_i      = '0;
    kill_if_i       = 1'b0;
    if_valid_i      = 1'b0;
    pc_if_i         = '0;
  endtask

  initial begin
    // Sequential arm, matching compare.
    vecs[0]  = mk(1, 0, 0, 0,            1, 32'h0000_1004, 0, 0, 0,             1, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0,            0, 0,             0, 1, 32'h0000_1004, 0, 0, 0);
    // Checkable pc_set, 5-cycle IF stall, then bit-1 mismatch.
    vecs[2]  = mk(1, 1, 1, 32'h0000_2000, 0, 0,            0, 0, 0,             1, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0,            0, 0,             0, 0, 0,             1, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0,            0, 0,             0, 0, 0,             1, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0,            0, 0,             0, 0, 0,             1, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0,            0, 0,             0, 0, 0,             1, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0,            0, 0,             0, 0, 0,             1, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0,            0, 0,             0, 1, 32'h0000_2002, 0, 1, 1);
    vecs[9]  = mk(1, 0, 0, 0,            0, 0,             0, 0, 0,             0, 0, 1);
    // Non-checkable pc_set discards; later IF content is not compared.
    vecs[10] = mk(1, 1, 1, 32'h0000_3000, 0, 0,            0, 0, 0,             1, 0, 1);
    vecs[11] = mk(1, 1, 0, 32'h0000_3000, 0, 0,            0, 0, 0,             0, 0, 1);
    vecs[12] = mk(1, 0, 0, 0,            0, 0,             0, 1, 32'h9999_0000, 0, 0, 1);
    // Back-to-back: compare 0x100 while arming 0x104, then 0x106 mismatches.
    vecs[13] = mk(1, 0, 0, 0,            1, 32'h0000_0100, 0, 0, 0,             1, 0, 1);
    vecs[14] = mk(1, 0, 0, 0,            1, 32'h0000_0104, 0, 1, 32'h0000_0100, 1, 0, 1);
    vecs[15] = mk(1, 0, 0, 0,            0, 0,             0, 1, 32'h0000_0106, 0, 1, 1);
    vecs[16] = mk(1, 0, 0, 0,            0, 0,             0, 0, 0,             0, 0, 1);
    // IGN_LSB=1: bit 0 ignored, bit 1 compared.
    vecs[17] = mk(1, 0, 0, 0,            1, 32'h0000_4000, 0, 0, 0,             1, 0, 1);
    vecs[18] = mk(1, 0, 0, 0,            0, 0,             0, 1, 32'h0000_4001, 0, 0, 1);
    vecs[19] = mk(1, 0, 0, 0,            1, 32'h0000_4000, 0, 0, 0,             1, 0, 1);
    vecs[20] = mk(1, 0, 0, 0,            0, 0,             0, 1, 32'h0000_4002, 0, 1, 1);
    vecs[21] = mk(1, 0, 0, 0,            0, 0,             0, 0, 0,             0, 0, 1);
    // Kill beats compare; pc_set suppresses compare; disable discards and blocks arming.
    vecs[22] = mk(1, 0, 0, 0,            1, 32'h0000_0500, 0, 0, 0,             1, 0, 1);
    vecs[23] = mk(1, 0, 0, 0,            0, 0,             1, 1, 32'h0000_0600, 0, 0, 1);
    vecs[24] = mk(1, 1, 1, 32'h0000_0700, 0, 0,            0, 1, 32'h0000_0888, 1, 0, 1);
    vecs[25] = mk(0, 0, 0, 0,            0, 0,             0, 1, 32'h0000_0999, 0, 0, 1);
    vecs[26] = mk(0, 0, 0, 0,            1, 32'h0000_0010, 0, 0, 0,             0, 0, 1);
    vecs[27] = mk(1, 0, 0, 0,            0, 0,             0, 1, 32'h0000_0020, 0, 0, 1);
    // Control-flow arm with matching compare.
    vecs[28] = mk(1, 1, 1, 32'h0000_0800, 0, 0,            0, 0, 0,             1, 0, 1);
    vecs[29] = mk(1, 0, 0, 0,            0, 0,             0, 1, 32'h0000_0800, 0, 0, 1);

    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pending", {31'd0, pending_o},    32'd0);
    check("reset_alert",   {31'd0, alert_o},      32'd0);
    check("reset_sticky",  {31'd0, err_sticky_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      enable_i        = vecs[i].en;
      pc_set_i        = vecs[i].ps;
      pc_set_chk_i    = vecs[i].chk;
      pc_set_target_i = vecs[i].tgt;
      seq_push_i      = vecs[i].sp;
      seq_addr_i      = vecs[i].sa;
      kill_if_i       = vecs[i].kill;
      if_valid_i      = vecs[i].iv;
      pc_if_i         = vecs[i].pc;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pending", i), {31'd0, pending_o},    {31'd0, vecs[i].e_pend});
      check($sformatf("v%0d_alert", i),   {31'd0, alert_o},      {31'd0, vecs[i].e_alert});
      check($sformatf("v%0d_sticky", i),  {31'd0, err_sticky_o}, {31'd0, vecs[i].e_sticky});
    end

`ifdef CV32E40S_PC_CHECK_STATS_EN
    check("stats_cmp_cnt",  {16'd0, cmp_cnt_o},  32'd7);
    check("stats_drop_cnt", {16'd0, drop_cnt_o}, 32'd3);
`endif

    // Async reset while ARM_CF holds an expectation that is about to mismatch.
    @(negedge clk);
    drive_idle();
    pc_set_i        = 1'b1;
    pc_set_chk_i    = 1'b1;
    pc_set_target_i = 32'h0000_5000;
    @(posedge clk);
    #1;
    check("rst_arm_pending", {31'd0, pending_o}, 32'd1);
    @(negedge clk);
    drive_idle();
    if_valid_i = 1'b1;
    pc_if_i    = 32'h0000_6000;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_pending", {31'd0, pending_o},    32'd0);
    check("rst_async_alert",   {31'd0, alert_o},      32'd0);
    check("rst_async_sticky",  {31'd0, err_sticky_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst%0d_pending", c), {31'd0, pending_o},    32'd0);
      check($sformatf("post_rst%0d_alert", c),   {31'd0, alert_o},      32'd0);
      check($sformatf("post_rst%0d_sticky", c),  {31'd0, err_sticky_o}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
